icache_ctrl: RTL and testbench
==============================

Name: icache_ctrl

Overview:
- Direct-mapped, read-only instruction-cache controller.
- Sequences an external 8-set × 256-bit data_array and holds the tag/valid store internally.
- Serves 32-bit fetches from the CPU fetch stage. On a miss, runs an 8-beat memory burst, assembles the line and refills data_array, then responds to the CPU.

Parameters:
- ADDR_W, 32, CPU/memory byte-address width.
- IDX_W, 3, set-index width; 1<<IDX_W sets; must match data_array address width.
- LINE_W, 256, line width in bits (8 × 32-bit words).
- TAG_W, ADDR_W-IDX_W-5, tag width (24 at defaults).

Ports:
- clk  in  1  clock; all state on posedge.
- resetn  in  1  asynchronous active-low reset.
- from_cpu_inst_req_valid  in  1  fetch request valid.
- from_cpu_inst_req_addr  in  ADDR_W  fetch byte address, word-aligned.
- to_cpu_inst_req_ready  out  1  controller can accept a request.
- to_cpu_cache_rsp_valid  out  1  fetched word valid.
- to_cpu_cache_rsp_data  out  32  fetched word.
- from_cpu_cache_rsp_ready  in  1  CPU accepts the response.
- to_mem_rd_req_valid  out  1  burst read request.
- to_mem_rd_req_addr  out  ADDR_W  line-aligned address, low 5 bits zero.
- from_mem_rd_req_ready  in  1  memory accepts the request.
- from_mem_rd_rsp_valid  in  1  burst beat valid.
- from_mem_rd_rsp_data  in  32  beat data.
- from_mem_rd_rsp_last  in  1  final beat of the burst.
- to_mem_rd_rsp_ready  out  1  controller accepts a beat.
- darray_raddr  out  IDX_W  data_array read index.
- darray_rdata  in  LINE_W  data_array read data; combinational from raddr.
- darray_waddr  out  IDX_W  data_array write index.
- darray_wen  out  1  data_array write enable.
- darray_wdata  out  LINE_W  refill line.

Behaviour:
- Address fields: offset [4:0]; word select [4:2]; index [IDX_W+4:5]; tag [ADDR_W-1:IDX_W+5].
- FSM states: WAIT, TAG_RD, HIT_RSP, MEM_REQ, RECV, REFILL, MISS_RSP. One-hot encoding.
- Reset (resetn low, async):
  - State goes to WAIT; all valid bits clear; beat counter 0.
  - All outputs 0: every valid, every ready, darray_wen, and the data/address outputs.
- WAIT:
  - to_cpu_inst_req_ready=1.
  - On valid&ready, latch the address into req_addr and go to TAG_RD.
- TAG_RD:
  - darray_raddr=index(req_addr).
  - hit = valid[idx] & (tag_store[idx]==tag).
  - hit -> HIT_RSP; miss -> MEM_REQ.
- HIT_RSP:
  - rsp_valid=1; rsp_data = darray_rdata word selected by req_addr[4:2].
  - Holds until rsp_ready, then WAIT.
  - Hit latency: request accepted at edge 0, rsp_valid high from cycle 2.
- MEM_REQ:
  - to_mem_rd_req_valid=1; addr = {req_addr[ADDR_W-1:5], 5'b0}.
  - Holds until from_mem_rd_req_ready, then RECV with beat counter cleared.
- RECV:
  - to_mem_rd_rsp_ready=1.
  - Each valid beat writes line_buf[32*cnt +: 32] and increments cnt (3-bit).
  - The beat with last -> REFILL. last is authoritative; an early last leaves the stale words of line_buf in place.
- REFILL (single cycle):
  - darray_wen=1, waddr=idx, wdata=line_buf.
  - tag_store[idx]<=tag; valid[idx]<=1. Then MISS_RSP.
- MISS_RSP:
  - rsp_data comes from line_buf (not darray), word select req_addr[4:2].
  - Holds until rsp_ready, then WAIT.
- darray_wen is 1 only in REFILL.
- No request is accepted outside WAIT; the next request after a response is accepted no earlier than the cycle after the handshake.
- resetn low mid-burst: FSM returns to WAIT immediately. Remaining memory beats are not the controller's concern; the bench must also reset memory.
- rsp_data is held stable while rsp_valid=1 and ready=0.

Decomposition:
- Shared package/header holds:
  - `define for IDX_W, LINE_W and offset width (5).
  - Field-extraction macros for tag/index/word.
  - State encoding constants.
- Optional sub-module icache_tag_array: 8 × (valid, TAG_W) registers, combinational read, sync write, async clear on resetn.
- data_array stays external, instantiated beside icache_ctrl in the cache top.

Test Plan:
- Cold miss:
  - Stimulus: reset, then fetch 0x0000_1004; memory returns beats 0xA0..0xA7.
  - Response: req_addr 0x0000_1000; darray write idx 0 with line {0xA7,...,0xA0}; rsp_data=0xA1.
- Hit after refill:
  - Stimulus: fetch 0x0000_101C.
  - Response: no memory request; rsp_valid at cycle 2; rsp_data=0xA7.
- Conflict miss:
  - Stimulus: fetch 0x0000_2000 (same idx 0, tag 0x20).
  - Response: new burst; tag replaced; a re-fetch of 0x0000_1000 misses again.
- Backpressure:
  - Stimulus: hold rsp_ready=0 for 5 cycles on a hit; hold mem req_ready=0 for 3 cycles.
  - Response: rsp_valid/data stable, no state advance; to_cpu_inst_req_ready=0 throughout.
- Beat stalls:
  - Stimulus: insert gaps between rsp_valid beats.
  - Response: line assembled in order; darray_wen pulses exactly once.
- Async reset mid-RECV:
  - Stimulus: drop resetn after 3 beats.
  - Response: all outputs 0 immediately; the next fetch to the same line misses.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache controller:
// address-field geometry, FSM state encoding and line word selection.
package icache_pkg;

  localparam int OFF_W          = 5;
  localparam int WORD_W         = 32;
  localparam int WORDS_PER_LINE = 8;
  localparam int DEF_ADDR_W     = 32;
  localparam int DEF_IDX_W      = 3;
  localparam int DEF_LINE_W     = 256;

  typedef enum logic [6:0] {
    S_WAIT     = 7'b000_0001,
    S_TAG_RD   = 7'b000_0010,
    S_HIT_RSP  = 7'b000_0100,
    S_MEM_REQ  = 7'b000_1000,
    S_RECV     = 7'b001_0000,
    S_REFILL   = 7'b010_0000,
    S_MISS_RSP = 7'b100_0000
  } state_e;

  function automatic logic [WORD_W-1:0] line_word(input logic [DEF_LINE_W-1:0] line,
                                                  input logic [2:0] sel);
    return line[{sel, 5'd0} +: WORD_W];
  endfunction

endpackage

// File: rtl/icache_tag_array.sv
// Valid/tag store: one entry per set, combinational read, synchronous write,
// all valid bits cleared by the asynchronous reset.
module icache_tag_array #(
  parameter int IDX_W = 3,
  parameter int TAG_W = 24
) (
  input  logic             i_clk,
  input  logic             i_resetn,
  input  logic [IDX_W-1:0] i_raddr,
  output logic             o_rvalid,
  output logic [TAG_W-1:0] o_rtag,
  input  logic             i_wen,
  input  logic [IDX_W-1:0] i_waddr,
  input  logic [TAG_W-1:0] i_wtag
);

  localparam int SETS = 1 << IDX_W;

  logic [SETS-1:0]  r_valid;
  logic [TAG_W-1:0] r_tag [SETS];

  // Entry update on refill; reset invalidates every set.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_valid <= '0;
      for (int i = 0; i < SETS; i++) begin
        r_tag[i] <= '0;
      end
    end else if (i_wen) begin
      r_valid[i_waddr] <= 1'b1;
      r_tag[i_waddr]   <= i_wtag;
    end
  end

  assign o_rvalid = r_valid[i_raddr];
  assign o_rtag   = r_tag[i_raddr];

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped read-only instruction cache controller: tag lookup, burst
// refill of an external data array and word response to the fetch stage.
module icache_ctrl
  import icache_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int IDX_W  = DEF_IDX_W,
  parameter int LINE_W = DEF_LINE_W,
  parameter int TAG_W  = ADDR_W - IDX_W - OFF_W
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              from_cpu_inst_req_valid,
  input  logic [ADDR_W-1:0] from_cpu_inst_req_addr,
  output logic              to_cpu_inst_req_ready,
  output logic              to_cpu_cache_rsp_valid,
  output logic [31:0]       to_cpu_cache_rsp_data,
  input  logic              from_cpu_cache_rsp_ready,
  output logic              to_mem_rd_req_valid,
  output logic [ADDR_W-1:0] to_mem_rd_req_addr,
  input  logic              from_mem_rd_req_ready,
  input  logic              from_mem_rd_rsp_valid,
  input  logic [31:0]       from_mem_rd_rsp_data,
  input  logic              from_mem_rd_rsp_last,
  output logic              to_mem_rd_rsp_ready,
  output logic [IDX_W-1:0]  darray_raddr,
  input  logic [LINE_W-1:0] darray_rdata,
  output logic [IDX_W-1:0]  darray_waddr,
  output logic              darray_wen,
  output logic [LINE_W-1:0] darray_wdata
);

  localparam int IDX_LO = OFF_W;
  localparam int TAG_LO = OFF_W + IDX_W;

  state_e              r_state;
  logic [ADDR_W-1:0]   r_req_addr;
  logic                r_req_ready;
  logic                r_rsp_valid;
  logic [31:0]         r_rsp_data;
  logic                r_mem_req_valid;
  logic [ADDR_W-1:0]   r_mem_req_addr;
  logic                r_mem_rsp_ready;
  logic [2:0]          r_cnt;
  logic [LINE_W-1:0]   r_line_buf;
  logic [IDX_W-1:0]    r_darray_raddr;
  logic [IDX_W-1:0]    r_darray_waddr;
  logic                r_darray_wen;
  logic [LINE_W-1:0]   r_darray_wdata;

  logic [IDX_W-1:0]    w_req_idx;
  logic [TAG_W-1:0]    w_req_tag;
  logic [2:0]          w_req_word;
  logic                w_tag_valid;
  logic [TAG_W-1:0]    w_tag_rd;
  logic                w_hit;
  logic                w_tag_wen;
  logic [LINE_W-1:0]   w_line_merged;
  logic                w_unused;

  assign w_req_idx  = r_req_addr[IDX_LO +: IDX_W];
  assign w_req_tag  = r_req_addr[ADDR_W-1:TAG_LO];
  assign w_req_word = r_req_addr[4:2];
  assign w_hit      = w_tag_valid && (w_tag_rd == w_req_tag);
  assign w_tag_wen  = (r_state == S_REFILL);
  assign w_unused   = &{1'b0, r_req_addr[1:0]};

  icache_tag_array #(
    .IDX_W(IDX_W),
    .TAG_W(TAG_W)
  ) u_tag_array (
    .i_clk    (clk),
    .i_resetn (resetn),
    .i_raddr  (w_req_idx),
    .o_rvalid (w_tag_valid),
    .o_rtag   (w_tag_rd),
    .i_wen    (w_tag_wen),
    .i_waddr  (w_req_idx),
    .i_wtag   (w_req_tag)
  );

  // Line buffer with the beat currently on the bus merged in, so the final
  // beat reaches the data array in the same refill write.
  always_comb begin
    w_line_merged = r_line_buf;
    if (from_mem_rd_rsp_valid) begin
      w_line_merged[{r_cnt, 5'd0} +: 32] = from_mem_rd_rsp_data;
    end else begin
      w_line_merged = r_line_buf;
    end
  end

  // Controller FSM; every output is a register updated on the transition
  // into the state that owns it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state         <= S_WAIT;
      r_req_addr      <= '0;
      r_req_ready     <= 1'b0;
      r_rsp_valid     <= 1'b0;
      r_rsp_data      <= 32'd0;
      r_mem_req_valid <= 1'b0;
      r_mem_req_addr  <= '0;
      r_mem_rsp_ready <= 1'b0;
      r_cnt           <= 3'd0;
      r_line_buf      <= '0;
      r_darray_raddr  <= '0;
      r_darray_waddr  <= '0;
      r_darray_wen    <= 1'b0;
      r_darray_wdata  <= '0;
    end else begin
      r_darray_wen <= 1'b0;
      case (r_state)
        S_WAIT: begin
          if (from_cpu_inst_req_valid && r_req_ready) begin
            r_req_addr     <= from_cpu_inst_req_addr;
            r_darray_raddr <= from_cpu_inst_req_addr[IDX_LO +: IDX_W];
            r_req_ready    <= 1'b0;
            r_state        <= S_TAG_RD;
          end else begin
            r_req_ready <= 1'b1;
          end
        end
        S_TAG_RD: begin
          if (w_hit) begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= line_word(darray_rdata, w_req_word);
            r_state     <= S_HIT_RSP;
          end else begin
            r_mem_req_valid <= 1'b1;
            r_mem_req_addr  <= {r_req_addr[ADDR_W-1:OFF_W], 5'd0};
            r_state         <= S_MEM_REQ;
          end
        end
        S_HIT_RSP, S_MISS_RSP: begin
          if (from_cpu_cache_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= S_WAIT;
          end
        end
        S_MEM_REQ: begin
          if (from_mem_rd_req_ready) begin
            r_mem_req_valid <= 1'b0;
            r_mem_rsp_ready <= 1'b1;
            r_cnt           <= 3'd0;
            r_state         <= S_RECV;
          end
        end
        S_RECV: begin
          if (from_mem_rd_rsp_valid) begin
            r_line_buf <= w_line_merged;
            r_cnt      <= r_cnt + 3'd1;
            if (from_mem_rd_rsp_last) begin
              r_mem_rsp_ready <= 1'b0;
              r_darray_wen    <= 1'b1;
              r_darray_waddr  <= w_req_idx;
              r_darray_wdata  <= w_line_merged;
              r_state         <= S_REFILL;
            end
          end
        end
        S_REFILL: begin
          // Respond from the line buffer; the data array read port still
          // reflects the pre-refill line.
          r_rsp_valid <= 1'b1;
          r_rsp_data  <= line_word(r_line_buf, w_req_word);
          r_state     <= S_MISS_RSP;
        end
        default: begin
          r_state <= S_WAIT;
        end
      endcase
    end
  end

  assign to_cpu_inst_req_ready  = r_req_ready;
  assign to_cpu_cache_rsp_valid = r_rsp_valid;
  assign to_cpu_cache_rsp_data  = r_rsp_data;
  assign to_mem_rd_req_valid    = r_mem_req_valid;
  assign to_mem_rd_req_addr     = r_mem_req_addr;
  assign to_mem_rd_rsp_ready    = r_mem_rsp_ready;
  assign darray_raddr           = r_darray_raddr;
  assign darray_waddr           = r_darray_waddr;
  assign darray_wen             = r_darray_wen;
  assign darray_wdata           = r_darray_wdata;

endmodule

// File: tb/tb_icache_ctrl.sv
// Bench for icache_ctrl: external data array and memory modelled here, with a
// set-level cache model predicting hit/miss, refill contents and responses.
module tb_icache_ctrl;

  logic         clk;
  logic         resetn;
  logic         from_cpu_inst_req_valid;
  logic [31:0]  from_cpu_inst_req_addr;
  logic         to_cpu_inst_req_ready;
  logic         to_cpu_cache_rsp_valid;
  logic [31:0]  to_cpu_cache_rsp_data;
  logic         from_cpu_cache_rsp_ready;
  logic         to_mem_rd_req_valid;
  logic [31:0]  to_mem_rd_req_addr;
  logic         from_mem_rd_req_ready;
  logic         from_mem_rd_rsp_valid;
  logic [31:0]  from_mem_rd_rsp_data;
  logic         from_mem_rd_rsp_last;
  logic         to_mem_rd_rsp_ready;
  logic [2:0]   darray_raddr;
  logic [255:0] darray_rdata;
  logic [2:0]   darray_waddr;
  logic         darray_wen;
  logic [255:0] darray_wdata;

  int n_vec = 0;
  int n_err = 0;

  logic [255:0] darray_mem [8];
  int           wen_count = 0;
  logic [2:0]   last_waddr;
  logic [255:0] last_wdata;

  // Cache model: what each set holds, plus the controller's line buffer.
  logic         m_valid [8];
  logic [23:0]  m_tag   [8];
  logic [31:0]  m_line  [8][8];
  logic [31:0]  m_buf   [8];
  logic [31:0]  beat_val [8];

  icache_ctrl dut (
    .clk                      (clk),
    .resetn                   (resetn),
    .from_cpu_inst_req_valid  (from_cpu_inst_req_valid),
    .from_cpu_inst_req_addr   (from_cpu_inst_req_addr),
    .to_cpu_inst_req_ready    (to_cpu_inst_req_ready),
    .to_cpu_cache_rsp_valid   (to_cpu_cache_rsp_valid),
    .to_cpu_cache_rsp_data    (to_cpu_cache_rsp_data),
    .from_cpu_cache_rsp_ready (from_cpu_cache_rsp_ready),
    .to_mem_rd_req_valid      (to_mem_rd_req_valid),
    .to_mem_rd_req_addr       (to_mem_rd_req_addr),
    .from_mem_rd_req_ready    (from_mem_rd_req_ready),
    .from_mem_rd_rsp_valid    (from_mem_rd_rsp_valid),
    .from_mem_rd_rsp_data     (from_mem_rd_rsp_data),
    .from_mem_rd_rsp_last     (from_mem_rd_rsp_last),
    .to_mem_rd_rsp_ready      (to_mem_rd_rsp_ready),
    .darray_raddr             (darray_raddr),
    .darray_rdata             (darray_rdata),
    .darray_waddr             (darray_waddr),
    .darray_wen               (darray_wen),
    .darray_wdata             (darray_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign darray_rdata = darray_mem[darray_raddr];

  always @(posedge clk) begin
    if (darray_wen) darray_mem[darray_waddr] <= darray_wdata;
  end

  always @(negedge clk) begin
    if (resetn && darray_wen) begin
      wen_count  <= wen_count + 1;
      last_waddr <= darray_waddr;
      last_wdata <= darray_wdata;
    end
  end

  task automatic check_val(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [255:0] model_line(input int idx);
    logic [255:0] v;
    for (int b = 0; b < 8; b++) v[32*b +: 32] = m_line[idx][b];
    return v;
  endfunction

  function automatic logic [511:0] all_outputs();
    return {to_cpu_inst_req_ready, to_cpu_cache_rsp_valid, to_cpu_cache_rsp_data,
            to_mem_rd_req_valid, to_mem_rd_req_addr, to_mem_rd_rsp_ready,
            darray_raddr, darray_waddr, darray_wen, darray_wdata};
  endfunction

  task automatic clear_inputs();
    from_cpu_inst_req_valid  = 1'b0;
    from_cpu_inst_req_addr   = 32'd0;
    from_cpu_cache_rsp_ready = 1'b0;
    from_mem_rd_req_ready    = 1'b0;
    from_mem_rd_rsp_valid    = 1'b0;
    from_mem_rd_rsp_data     = 32'd0;
    from_mem_rd_rsp_last     = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 1'b0;
      m_buf[i]   = 32'd0;
    end
  endtask

  task automatic issue_req(input logic [31:0] addr);
    int c;
    c = 0;
    while (!to_cpu_inst_req_ready && c < 20) begin
      @(negedge clk);
      c++;
    end
    check_val("req_ready_idle", to_cpu_inst_req_ready, 1);
    from_cpu_inst_req_valid = 1'b1;
    from_cpu_inst_req_addr  = addr;
    @(negedge clk);
    from_cpu_inst_req_valid = 1'b0;
    from_cpu_inst_req_addr  = $urandom;
    check_val("req_ready_busy", to_cpu_inst_req_ready, 0);
  endtask

  // Full fetch transaction: n_beats beats from beat_val, last on the final one.
  task automatic fetch(input logic [31:0] addr, input int n_beats, input int req_stall,
                       input int rsp_stall, input int gap_max);
    int idx, w, c, wen0;
    logic exp_hit, saw_mem, done;
    logic [31:0] held;
    idx     = int'(addr[7:5]);
    w       = int'(addr[4:2]);
    exp_hit = m_valid[idx] && (m_tag[idx] == addr[31:8]);
    wen0    = wen_count;
    issue_req(addr);
    c = 1; saw_mem = 1'b0; done = 1'b0;
    while (!done && c < 300) begin
      if (to_mem_rd_req_valid && !saw_mem) begin
        saw_mem = 1'b1;
        check_val("mem_addr", to_mem_rd_req_addr, {addr[31:5], 5'd0});
        for (int s = 0; s < req_stall; s++) begin
          @(negedge clk); c++;
          check_val("mem_req_hold", {to_mem_rd_req_valid, to_cpu_inst_req_ready, to_mem_rd_req_addr},
                    {1'b1, 1'b0, addr[31:5], 5'd0});
        end
        from_mem_rd_req_ready = 1'b1;
        @(negedge clk); c++;
        from_mem_rd_req_ready = 1'b0;
        for (int b = 0; b < n_beats; b++) begin
          int g;
          g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
          repeat (g) begin @(negedge clk); c++; end
          check_val("beat_ready", to_mem_rd_rsp_ready, 1);
          from_mem_rd_rsp_valid = 1'b1;
          from_mem_rd_rsp_data  = beat_val[b];
          from_mem_rd_rsp_last  = (b == n_beats - 1);
          @(negedge clk); c++;
          from_mem_rd_rsp_valid = 1'b0;
          from_mem_rd_rsp_last  = 1'b0;
          m_buf[b] = beat_val[b];
        end
        for (int b = 0; b < 8; b++) m_line[idx][b] = m_buf[b];
        m_valid[idx] = 1'b1;
        m_tag[idx]   = addr[31:8];
      end else if (to_cpu_cache_rsp_valid) begin
        if (exp_hit) check_val("hit_latency", c, 2);
        check_val("rsp_data", to_cpu_cache_rsp_data, m_line[idx][w]);
        held = to_cpu_cache_rsp_data;
        for (int s = 0; s < rsp_stall; s++) begin
          @(negedge clk); c++;
          check_val("rsp_hold", {to_cpu_cache_rsp_valid, to_cpu_cache_rsp_data, to_cpu_inst_req_ready},
                    {1'b1, held, 1'b0});
        end
        from_cpu_cache_rsp_ready = 1'b1;
        @(negedge clk);
        from_cpu_cache_rsp_ready = 1'b0;
        check_val("rsp_done", {to_cpu_cache_rsp_valid, to_cpu_inst_req_ready}, 2'b01);
        done = 1'b1;
      end else begin
        @(negedge clk); c++;
      end
    end
    check_val("fetch_done", done, 1);
    check_val("hit_vs_miss", saw_mem, !exp_hit);
    check_val("wen_pulses", wen_count - wen0, exp_hit ? 0 : 1);
    if (!exp_hit && saw_mem) begin
      check_val("refill_idx", last_waddr, idx);
      check_val("refill_line", last_wdata, model_line(idx));
    end
  endtask

  task automatic set_beats(input logic [31:0] base);
    for (int b = 0; b < 8; b++) beat_val[b] = base + b;
  endtask

  task automatic reset_mid_recv(input logic [31:0] addr);
    int c;
    set_beats(32'h0000_00C0);
    issue_req(addr);
    c = 0;
    while (!to_mem_rd_req_valid && c < 20) begin @(negedge clk); c++; end
    check_val("rst_test_mem_req", to_mem_rd_req_valid, 1);
    from_mem_rd_req_ready = 1'b1;
    @(negedge clk);
    from_mem_rd_req_ready = 1'b0;
    for (int b = 0; b < 3; b++) begin
      from_mem_rd_rsp_valid = 1'b1;
      from_mem_rd_rsp_data  = beat_val[b];
      @(negedge clk);
    end
    resetn = 1'b0;
    #1;
    check_val("outputs_mid_reset", all_outputs(), '0);
    clear_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      darray_mem[i] = '0;
      m_tag[i]      = 24'd0;
      for (int b = 0; b < 8; b++) m_line[i][b] = 32'd0;
    end
    model_reset();
    clear_inputs();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    check_val("outputs_in_reset", all_outputs(), '0);
    resetn = 1'b1;

    // Cold miss, then hit with response backpressure.
    set_beats(32'h0000_00A0);
    fetch(32'h0000_1004, 8, 0, 0, 0);
    check_val("cold_rsp", m_line[0][1], 32'h0000_00A1);
    fetch(32'h0000_101C, 8, 0, 5, 0);

    // Conflict miss with request backpressure, then the old tag misses again.
    set_beats(32'h0000_00B0);
    fetch(32'h0000_2000, 8, 3, 0, 0);
    set_beats(32'h0000_00A0);
    fetch(32'h0000_1000, 8, 0, 0, 0);

    // Gapped beats into set 2.
    set_beats(32'h1234_5000);
    fetch(32'h0000_1048, 8, 1, 2, 3);

    // Reset while beats are arriving; both lines must miss afterwards.
    reset_mid_recv(32'h0000_2040);
    set_beats(32'h0000_0D00);
    fetch(32'h0000_2044, 8, 0, 0, 0);
    set_beats(32'h0000_0E00);
    fetch(32'h0000_1048, 8, 0, 0, 1);

    // Randomized fetches over a small address pool, including early-last bursts.
    for (int t = 0; t < 40; t++) begin
      logic [31:0] a;
      logic [23:0] tg;
      int nb;
      case ($urandom_range(0, 2))
        0: tg = 24'h000010;
        1: tg = 24'h000020;
        default: tg = 24'h000011;
      endcase
      a = {tg, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 2'b00};
      for (int b = 0; b < 8; b++) beat_val[b] = $urandom;
      nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 8;
      fetch(a, nb, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
